mac_job_sequencer: RTL and testbench

//  Control/feed stage placed directly upstream of systolic_array.
//  - Accepts one job command: k_len, the number of reduction groups.
//  - Buffers the incoming operand beats into whole SLICES-beat groups.
//  - Injects each group into the array aligned to the array's slice phase.
//  - After a drain period, issues the single-cycle readout pulse.
//  - Frames the W*H serial results with valid/last/index.

---
 rtl/mac_job_sequencer_pkg.sv | 36 +++
 rtl/mac_job_sequencer_if.sv | 44 ++++
 rtl/mac_job_sequencer_group_pingpong_buf.sv | 87 ++++++++
 rtl/mac_job_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_mac_job_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_job_sequencer_pkg.sv
// Shared definitions for the MAC job sequencer.
// Holds the array geometry derived from the slice count, the sequencer
// FSM state encoding and small helpers that size counters and indices.
package mac_job_sequencer_pkg;

  localparam int SLICES_DEFAULT = 4;

  // Array geometry for the default slice count.
  localparam int W        = SLICES_DEFAULT;
  localparam int H        = 2 * SLICES_DEFAULT;
  localparam int NRES     = W * H;
  localparam int IDX_BITS = $clog2(NRES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIRE  = 2'd3
  } state_e;

  // Number of serial results produced by a W x H array.
  function automatic int calc_nres(input int s);
    return 2 * s * s;
  endfunction

  // Width of the result index (0..NRES-1).
  function automatic int calc_idx_bits(input int s);
    return $clog2(2 * s * s);
  endfunction

  // Width of a beat-within-group index; at least one bit.
  function automatic int calc_slice_bits(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/mac_job_sequencer_if.sv
// Bundle of the sequencer's handshake and array-facing signals.
//  master : upstream job/operand source plus the array result return
//  slave  : the sequencer itself
//  cmd_*  : job command (k_len groups)      in_*  : operand beats
//  arr_*  : drive to / return from the array out_* : framed result stream
interface mac_job_sequencer_if
  import mac_job_sequencer_pkg::*;
#(
  parameter int SLICES = SLICES_DEFAULT,
  parameter int K_BITS = 8
) ();

  localparam int IDX_W = calc_idx_bits(SLICES);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [K_BITS-1:0] cmd_k_len;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_left;
  logic [7:0]        in_top;
  logic [7:0]        arr_left;
  logic [7:0]        arr_top;
  logic              arr_readout;
  logic [7:0]        arr_out;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_last;
  logic [IDX_W-1:0]  out_index;
  logic              busy;

  modport master (
    output cmd_valid, cmd_k_len, in_valid, in_left, in_top, arr_out,
    input  cmd_ready, in_ready, arr_left, arr_top, arr_readout,
           out_valid, out_data, out_last, out_index, busy
  );

  modport slave (
    input  cmd_valid, cmd_k_len, in_valid, in_left, in_top, arr_out,
    output cmd_ready, in_ready, arr_left, arr_top, arr_readout,
           out_valid, out_data, out_last, out_index, busy
  );

endinterface

// File: rtl/mac_job_sequencer_group_pingpong_buf.sv
// Two-bank ping-pong buffer holding whole SLICES-beat operand groups.
// Ports:
//  clk, reset       : clock, synchronous active-high reset (flushes banks)
//  wr_valid/ready   : accepted beat written into the current write bank
//  wr_data          : {left, top} beat
//  wr_last          : next accepted beat completes the write bank
//  rd_avail         : read bank holds a complete group
//  rd_beat, rd_idx  : a beat at index rd_idx is consumed this cycle
//  rd_data          : read bank entry at rd_idx (combinational)
module group_pingpong_buf
  import mac_job_sequencer_pkg::*;
#(
  parameter  int SLICES = SLICES_DEFAULT,
  localparam int IW     = calc_slice_bits(SLICES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [15:0]   wr_data,
  output logic          wr_last,
  output logic          rd_avail,
  input  logic          rd_beat,
  input  logic [IW-1:0] rd_idx,
  output logic [15:0]   rd_data
);

  logic [15:0]   bank_q [0:1][0:SLICES-1];
  logic [15:0]   bank_d [0:1][0:SLICES-1];
  logic [1:0]    full_q, full_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          rd_ptr_q, rd_ptr_d;

  assign wr_ready = ~full_q[wr_ptr_q];
  assign wr_last  = (wr_idx_q == IW'(SLICES - 1));
  assign rd_avail = full_q[rd_ptr_q];
  assign rd_data  = bank_q[rd_ptr_q][rd_idx];

  // Next-state of banks, full flags and pointers.
  always_comb begin
    bank_d   = bank_q;
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    wr_idx_d = wr_idx_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_valid && wr_ready) begin
      bank_d[wr_ptr_q][wr_idx_q] = wr_data;
      if (wr_idx_q == IW'(SLICES - 1)) begin
        // Bank complete: publish it and move to the other bank.
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ~wr_ptr_q;
        wr_idx_d         = {IW{1'b0}};
      end else begin
        wr_idx_d = wr_idx_q + IW'(1);
      end
    end else begin
      wr_idx_d = wr_idx_q;
    end
    // Read and write banks always differ while reading, so both
    // updates to full_d may happen in the same cycle.
    if (rd_beat && (rd_idx == IW'(SLICES - 1))) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q   <= '{default: 16'h0000};
      full_q   <= 2'b00;
      wr_ptr_q <= 1'b0;
      wr_idx_q <= {IW{1'b0}};
      rd_ptr_q <= 1'b0;
    end else begin
      bank_q   <= bank_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      wr_idx_q <= wr_idx_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/mac_job_sequencer.sv
// Control/feed stage in front of the systolic array.
// Accepts a job of k_len groups, buffers operand beats into whole groups,
// injects each group aligned to the array slice phase, waits a drain
// period, pulses arr_readout and frames the W*H serial results.
// Ports:
//  clk, reset : clock, synchronous active-high reset
//  bus        : cmd_*, in_*, arr_*, out_*, busy (see mac_job_sequencer_if)
module mac_job_sequencer
  import mac_job_sequencer_pkg::*;
#(
  parameter int SLICES = SLICES_DEFAULT,
  parameter int K_BITS = 8,
  parameter int DRAIN  = 2 * SLICES
) (
  input  logic                clk,
  input  logic                reset,
  mac_job_sequencer_if.slave  bus
);

  localparam int IW    = calc_slice_bits(SLICES);
  localparam int NRES_L = calc_nres(SLICES);
  localparam int IXW   = calc_idx_bits(SLICES);
  localparam int DW    = $clog2(DRAIN + 1);
  localparam int GW    = K_BITS + 1;

  state_e            state_q, state_d;
  logic [IW-1:0]     phase_q, phase_d;
  logic              inj_q, inj_d;
  logic [K_BITS-1:0] k_len_q, k_len_d;
  logic [GW-1:0]     recv_groups_q, recv_groups_d;
  logic [GW-1:0]     sent_groups_q, sent_groups_d;
  logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [IXW-1:0]    out_index_q, out_index_d;
  logic [7:0]        arr_left_q, arr_left_d;
  logic [7:0]        arr_top_q, arr_top_d;
  logic              arr_readout_q, arr_readout_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;

  logic              wr_ready_s, wr_last_s, rd_avail_s;
  logic [15:0]       rd_data_s;
  logic              in_ready_s, in_fire_s, grp_sent_s;

  assign in_ready_s = (state_q == ST_RUN) && (recv_groups_q < {1'b0, k_len_q}) && wr_ready_s;
  assign in_fire_s  = bus.in_valid && in_ready_s;

  group_pingpong_buf #(.SLICES(SLICES)) u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (in_fire_s),
    .wr_ready (wr_ready_s),
    .wr_data  ({bus.in_left, bus.in_top}),
    .wr_last  (wr_last_s),
    .rd_avail (rd_avail_s),
    .rd_beat  (inj_d),
    .rd_idx   (phase_d),
    .rd_data  (rd_data_s)
  );

  // Phase mirror of the array slice counter and group-injection decision.
  // The decision to inject is taken only when the next phase is 0, so a
  // group always occupies phases 0..SLICES-1 of one array slice cycle.
  always_comb begin
    if (arr_readout_q || (phase_q == IW'(SLICES - 1))) begin
      phase_d = {IW{1'b0}};
    end else begin
      phase_d = phase_q + IW'(1);
    end
    if (phase_d == {IW{1'b0}}) begin
      inj_d = rd_avail_s && (state_q == ST_RUN);
    end else begin
      inj_d = inj_q;
    end
    grp_sent_s = inj_d && (phase_d == IW'(SLICES - 1));
  end

  // FSM, group counters, drain counter, readout framing and output regs.
  always_comb begin
    state_d       = state_q;
    k_len_d       = k_len_q;
    recv_groups_d = recv_groups_q;
    sent_groups_d = sent_groups_q;
    drain_cnt_d   = drain_cnt_q;
    out_valid_d   = out_valid_q;
    out_index_d   = out_index_q;

    arr_left_d = inj_d ? rd_data_s[15:8] : 8'h00;
    arr_top_d  = inj_d ? rd_data_s[7:0]  : 8'h00;

    if (in_fire_s && wr_last_s) begin
      recv_groups_d = recv_groups_q + GW'(1);
    end else begin
      recv_groups_d = recv_groups_q;
    end
    if (grp_sent_s) begin
      sent_groups_d = sent_groups_q + GW'(1);
    end else begin
      sent_groups_d = sent_groups_q;
    end

    // Readout framing runs independently of the FSM once started.
    if (arr_readout_q) begin
      out_valid_d = 1'b1;
      out_index_d = {IXW{1'b0}};
    end else if (out_valid_q) begin
      if (out_index_q == IXW'(NRES_L - 1)) begin
        out_valid_d = 1'b0;
        out_index_d = {IXW{1'b0}};
      end else begin
        out_index_d = out_index_q + IXW'(1);
      end
    end else begin
      out_index_d = {IXW{1'b0}};
    end
    out_last_d = out_valid_d && (out_index_d == IXW'(NRES_L - 1));

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          k_len_d       = bus.cmd_k_len;
          recv_groups_d = {GW{1'b0}};
          sent_groups_d = {GW{1'b0}};
          // A zero-length job is accepted but never leaves IDLE.
          if (bus.cmd_k_len != {K_BITS{1'b0}}) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (grp_sent_s && ((sent_groups_q + GW'(1)) == {1'b0, k_len_q})) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = {DW{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DW'(DRAIN - 1)) begin
          // Hold until the previous readout has issued its last byte.
          if (!out_valid_q || out_last_q) begin
            state_d = ST_FIRE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      ST_FIRE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    arr_readout_d = (state_d == ST_FIRE);
    cmd_ready_d   = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE) || out_valid_d;
  end

  // All sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= {IW{1'b0}};
      inj_q         <= 1'b0;
      k_len_q       <= {K_BITS{1'b0}};
      recv_groups_q <= {GW{1'b0}};
      sent_groups_q <= {GW{1'b0}};
      drain_cnt_q   <= {DW{1'b0}};
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_index_q   <= {IXW{1'b0}};
      arr_left_q    <= 8'h00;
      arr_top_q     <= 8'h00;
      arr_readout_q <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      inj_q         <= inj_d;
      k_len_q       <= k_len_d;
      recv_groups_q <= recv_groups_d;
      sent_groups_q <= sent_groups_d;
      drain_cnt_q   <= drain_cnt_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_index_q   <= out_index_d;
      arr_left_q    <= arr_left_d;
      arr_top_q     <= arr_top_d;
      arr_readout_q <= arr_readout_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.in_ready    = in_ready_s;
  assign bus.arr_left    = arr_left_q;
  assign bus.arr_top     = arr_top_q;
  assign bus.arr_readout = arr_readout_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = bus.arr_out;
  assign bus.out_last    = out_last_q;
  assign bus.out_index   = out_index_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with SLICES=2 (W=2, H=4, 8 results).
// A small behavioural stand-in for the systolic array tracks the slice
// phase, accumulates one product per injected group and returns
// (acc >> 8) as the result byte after each readout pulse.
module tb_mac_job_sequencer;

  localparam int S = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Array stand-in state.
  int   mph = 0;
  int   acc = 0;
  logic grp_nz = 1'b0;
  int   nz_groups = 0;
  int   misalign = 0;
  int   fire_cnt = 0;
  int   fire_cyc = -10;
  logic [7:0] out_lat = 8'h00;

  mac_job_sequencer_if #(.SLICES(S), .K_BITS(8)) bus ();

  mac_job_sequencer #(.SLICES(S), .K_BITS(8), .DRAIN(2 * S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Array stand-in, evaluated mid-cycle on the current cycle's values.
  always @(negedge clk) begin
    logic signed [3:0] l4;
    logic signed [7:0] t8;
    logic nz;
    l4 = bus.arr_left[3:0];
    t8 = bus.arr_top;
    nz = (bus.arr_left != 8'h00) || (bus.arr_top != 8'h00);
    if (mph == 0) begin
      grp_nz = nz;
      if (nz) begin
        nz_groups++;
        acc = acc + int'(l4) * int'(t8);
      end
    end else if (nz != grp_nz) begin
      misalign++;
    end
    if (bus.arr_readout) begin
      fire_cnt++;
      fire_cyc = cyc;
      out_lat  = acc[15:8];
      acc      = 0;
    end
    bus.arr_out = out_lat;
    if (reset) begin
      mph = 0; acc = 0; grp_nz = 1'b0;
    end else if (bus.arr_readout) begin
      mph = 0;
    end else begin
      mph = (mph == S - 1) ? 0 : mph + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] k);
    int w = 0;
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_k_len = k;
    while (!bus.cmd_ready && w < 100) begin
      tick();
      w++;
    end
    check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] l, input logic [7:0] t, input bit toggle);
    int got = 0;
    int c = 0;
    bus.in_left = l;
    bus.in_top  = t;
    while (got < n && c < 2000) begin
      tick();
      c++;
      if (toggle && (c % 2 == 0)) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        if (bus.in_ready) got++;
      end
    end
    tick();
    bus.in_valid = 1'b0;
    check("beats_accepted", 32'(got), 32'(n));
  endtask

  task automatic collect(input string tag, input logic [7:0] expv, output int last_c);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.out_valid && w < 400);
    check({tag, "_start"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_p_plus_1"}, 32'(cyc), 32'(fire_cyc + 1));
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("%s_valid%0d", tag, i), 32'(bus.out_valid), 32'd1);
      check($sformatf("%s_data%0d", tag, i), 32'(bus.out_data), 32'(expv));
      check($sformatf("%s_index%0d", tag, i), 32'(bus.out_index), 32'(i));
      check($sformatf("%s_last%0d", tag, i), 32'(bus.out_last), (i == 7) ? 32'd1 : 32'd0);
    end
    last_c = cyc;
    @(negedge clk);
    check({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int last1, last2, g0, f0, w;
    logic any_busy, any_rdy, any_ro;
    bus.cmd_valid = 1'b0;
    bus.cmd_k_len = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_left   = 8'h00;
    bus.in_top    = 8'h00;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_arr_left", 32'(bus.arr_left), 32'd0);
    check("rst_arr_readout", 32'(bus.arr_readout), 32'd0);
    tick();
    reset = 1'b0;

    // Test 1: one group of (-8,-8) x -128 -> 1024 >> 8 = 0x04.
    f0 = fire_cnt;
    send_cmd(8'd1);
    feed(2, 8'h88, 8'h80, 1'b0);
    collect("t1", 8'h04, last1);
    check("t1_fires", 32'(fire_cnt - f0), 32'd1);

    // Test 2: 128 groups of 7 x 127 -> 113792 >> 8 = 0x1BC -> 0xBC.
    g0 = nz_groups;
    send_cmd(8'd128);
    feed(256, 8'h77, 8'h7F, 1'b0);
    collect("t2", 8'hBC, last1);
    check("t2_groups", 32'(nz_groups - g0), 32'd128);

    // Test 3: gappy input still injects only whole aligned groups.
    g0 = nz_groups;
    send_cmd(8'd1);
    feed(2, 8'h88, 8'h80, 1'b1);
    collect("t3", 8'h04, last1);
    check("t3_groups", 32'(nz_groups - g0), 32'd1);
    check("t3_misalign", 32'(misalign), 32'd0);

    // Test 4: second job issued during the first readout.
    send_cmd(8'd1);
    feed(2, 8'h88, 8'h80, 1'b0);
    fork
      begin
        collect("t4a", 8'h04, last1);
        collect("t4b", 8'h04, last2);
      end
      begin
        f0 = fire_cnt;
        w = 0;
        while (fire_cnt == f0 && w < 400) begin
          @(negedge clk);
          w++;
        end
        send_cmd(8'd1);
        feed(2, 8'h88, 8'h80, 1'b0);
      end
    join
    check("t4_fire_after_last", 32'(fire_cyc > last1), 32'd1);

    // Test 5: zero-length job is a no-op.
    f0 = fire_cnt;
    send_cmd(8'd0);
    any_busy = 1'b0; any_rdy = 1'b0; any_ro = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_busy |= bus.busy;
      any_rdy  |= bus.in_ready;
      any_ro   |= bus.arr_readout;
    end
    check("t5_busy", 32'(any_busy), 32'd0);
    check("t5_in_ready", 32'(any_rdy), 32'd0);
    check("t5_readout", 32'(any_ro), 32'd0);
    check("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Test 6a: reset in the middle of a job.
    send_cmd(8'd2);
    feed(2, 8'h88, 8'h80, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6a_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6a_arr_left", 32'(bus.arr_left), 32'd0);
    check("t6a_arr_top", 32'(bus.arr_top), 32'd0);
    check("t6a_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("t6a_busy", 32'(bus.busy), 32'd0);

    // Test 6b: reset in the middle of a readout.
    send_cmd(8'd1);
    feed(2, 8'h88, 8'h80, 1'b0);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.out_valid && w < 400);
    check("t6b_readout_seen", 32'(bus.out_valid), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6b_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6b_arr_left", 32'(bus.arr_left), 32'd0);
    check("t6b_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Following job still yields 0x04.
    send_cmd(8'd1);
    feed(2, 8'h88, 8'h80, 1'b0);
    collect("t6c", 8'h04, last1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
